// File: rtl/bp_nbf_axil_deserializer.sv
// AXI-Lite write-only target that reassembles five 32-bit words written to the
// NBF host address into one 136-bit NBF command and presents it on a
// valid/ready stream. The read channel returns a status word holding the
// number of transferred commands and the sticky finish flag.
module bp_nbf_axil_deserializer #(
   parameter int S_AXIL_ADDR_WIDTH = 64,
   parameter int S_AXIL_DATA_WIDTH = 32,
   parameter logic [S_AXIL_ADDR_WIDTH-1:0] nbf_host_addr_p = {S_AXIL_ADDR_WIDTH{1'b0}}
) (
   input  logic                           s_axil_aclk,
   input  logic                           s_axil_aresetn,

   input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
   input  logic                           s_axil_awvalid,
   output logic                           s_axil_awready,
   input  logic [2:0]                     s_axil_awprot,

   input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
   input  logic                           s_axil_wvalid,
   output logic                           s_axil_wready,
   input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,

   output logic [1:0]                     s_axil_bresp,
   output logic                           s_axil_bvalid,
   input  logic                           s_axil_bready,

   input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
   input  logic                           s_axil_arvalid,
   output logic                           s_axil_arready,
   input  logic [2:0]                     s_axil_arprot,

   output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
   output logic [1:0]                     s_axil_rresp,
   output logic                           s_axil_rvalid,
   input  logic                           s_axil_rready,

   output logic [7:0]                     nbf_opcode_o,
   output logic [63:0]                    nbf_addr_o,
   output logic [63:0]                    nbf_data_o,
   output logic                           nbf_v_o,
   input  logic                           nbf_ready_i,
   output logic                           finish_o
);

   localparam logic [1:0] resp_okay_lp   = 2'b00;
   localparam logic [1:0] resp_slverr_lp = 2'b10;
   localparam logic [2:0] last_word_lp   = 3'd4;

   // Holding registers for the independent AW and W channels
   logic                         aw_full_r;
   logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr_r;
   logic                         w_full_r;
   logic [31:0]                  w_data_r;

   // Assembly state: word index and slots 0..3 (slot 4 goes straight out)
   logic [2:0]   word_r;
   logic [127:0] flit_r;

   // Output command register and status
   logic         nbf_v_r;
   logic [7:0]   opcode_r;
   logic [63:0]  addr_r;
   logic [63:0]  data_r;
   logic         finish_r;
   logic [30:0]  cmd_count_r;

   // Response channels
   logic         bvalid_r;
   logic [1:0]   bresp_r;
   logic         rvalid_r;
   logic [31:0]  rdata_r;

   logic         awready_s;
   logic         wready_s;
   logic         arready_s;
   logic         aw_fire_s;
   logic         w_fire_s;
   logic         ar_fire_s;
   logic         addr_match_s;
   logic         last_word_s;
   logic         nbf_xfer_s;
   logic         stall_s;
   logic         commit_s;
   logic         load_s;
   logic         unused_s;

   // Ready signals are held low while reset is asserted
   assign awready_s    = s_axil_aresetn & ~aw_full_r;
   assign wready_s     = s_axil_aresetn & ~w_full_r;
   assign arready_s    = s_axil_aresetn & ~rvalid_r;
   assign aw_fire_s    = s_axil_awvalid & awready_s;
   assign w_fire_s     = s_axil_wvalid & wready_s;
   assign ar_fire_s    = s_axil_arvalid & arready_s;

   assign addr_match_s = (aw_addr_r == nbf_host_addr_p);
   assign last_word_s  = (word_r == last_word_lp);
   assign nbf_xfer_s   = nbf_v_r & nbf_ready_i;
   // The fifth word waits for the output register, unless it drains this cycle
   assign stall_s      = last_word_s & nbf_v_r & ~nbf_ready_i;
   assign commit_s     = aw_full_r & w_full_r & ~bvalid_r & ~stall_s;
   assign load_s       = commit_s & addr_match_s & last_word_s;

   // Protection bits, byte strobes, read address and the top of slot 4 carry no meaning here
   assign unused_s = ^{s_axil_awprot, s_axil_wstrb, s_axil_araddr, s_axil_arprot,
                       w_data_r[31:8], s_axil_wdata};

   // AW holding register: fill on handshake, drain on commit
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         aw_full_r <= 1'b0;
         aw_addr_r <= {S_AXIL_ADDR_WIDTH{1'b0}};
      end else if (aw_fire_s) begin
         aw_full_r <= 1'b1;
         aw_addr_r <= s_axil_awaddr;
      end else if (commit_s) begin
         aw_full_r <= 1'b0;
      end
   end

   // W holding register: fill on handshake, drain on commit
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         w_full_r <= 1'b0;
         w_data_r <= 32'h0;
      end else if (w_fire_s) begin
         w_full_r <= 1'b1;
         w_data_r <= s_axil_wdata[31:0];
      end else if (commit_s) begin
         w_full_r <= 1'b0;
      end
   end

   // Word index and flit slots advance only on matching commits
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         word_r <= 3'd0;
         flit_r <= 128'h0;
      end else if (commit_s && addr_match_s) begin
         case (word_r)
            3'd0:    flit_r[31:0]   <= w_data_r;
            3'd1:    flit_r[63:32]  <= w_data_r;
            3'd2:    flit_r[95:64]  <= w_data_r;
            3'd3:    flit_r[127:96] <= w_data_r;
            default: flit_r         <= flit_r;
         endcase
         word_r <= last_word_s ? 3'd0 : (word_r + 3'd1);
      end
   end

   // Output command register: load on fifth word, release on transfer
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         nbf_v_r  <= 1'b0;
         opcode_r <= 8'h0;
         addr_r   <= 64'h0;
         data_r   <= 64'h0;
      end else if (load_s) begin
         nbf_v_r  <= 1'b1;
         opcode_r <= w_data_r[7:0];
         addr_r   <= flit_r[127:64];
         data_r   <= flit_r[63:0];
      end else if (nbf_xfer_s) begin
         nbf_v_r  <= 1'b0;
      end
   end

   // Transfer counter and sticky finish flag
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         cmd_count_r <= 31'd0;
         finish_r    <= 1'b0;
      end else if (nbf_xfer_s) begin
         cmd_count_r <= cmd_count_r + 31'd1;
         finish_r    <= finish_r | (opcode_r == 8'hFF);
      end
   end

   // Write response: set on commit, cleared on handshake
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         bvalid_r <= 1'b0;
         bresp_r  <= resp_okay_lp;
      end else if (commit_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= addr_match_s ? resp_okay_lp : resp_slverr_lp;
      end else if (bvalid_r && s_axil_bready) begin
         bvalid_r <= 1'b0;
      end
   end

   // Read response: snapshot status on address accept, cleared on handshake
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0;
      end else if (ar_fire_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= {cmd_count_r, finish_r};
      end else if (rvalid_r && s_axil_rready) begin
         rvalid_r <= 1'b0;
      end
   end

   assign s_axil_awready = awready_s;
   assign s_axil_wready  = wready_s;
   assign s_axil_arready = arready_s;
   assign s_axil_bvalid  = bvalid_r;
   assign s_axil_bresp   = bresp_r;
   assign s_axil_rvalid  = rvalid_r;
   assign s_axil_rdata   = {{(S_AXIL_DATA_WIDTH-32){1'b0}}, rdata_r};
   assign s_axil_rresp   = resp_okay_lp;
   assign nbf_v_o        = nbf_v_r;
   assign nbf_opcode_o   = opcode_r;
   assign nbf_addr_o     = addr_r;
   assign nbf_data_o     = data_r;
   assign finish_o       = finish_r;

endmodule

// File: tb/tb_bp_nbf_axil_deserializer.sv
// Directed bench for bp_nbf_axil_deserializer: writes NBF words over AXI-Lite,
// collects transferred commands and compares against hand-computed values.
module tb_bp_nbf_axil_deserializer;

   logic         clk;
   logic         rst_n;
   logic [63:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [2:0]   awprot;
   logic [31:0]  wdata;
   logic         wvalid;
   logic         wready;
   logic [3:0]   wstrb;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [63:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [2:0]   arprot;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [7:0]   nbf_opcode;
   logic [63:0]  nbf_addr;
   logic [63:0]  nbf_data;
   logic         nbf_v;
   logic         nbf_ready;
   logic         finish;

   int checks   = 0;
   int failures = 0;
   logic [135:0] cmd_q[$];

   localparam logic [63:0] host_lp = 64'h0;
   localparam logic [63:0] bad_lp  = 64'h4;

   bp_nbf_axil_deserializer dut (
      .s_axil_aclk    (clk),
      .s_axil_aresetn (rst_n),
      .s_axil_awaddr  (awaddr),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_awprot  (awprot),
      .s_axil_wdata   (wdata),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_wstrb   (wstrb),
      .s_axil_bresp   (bresp),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .s_axil_araddr  (araddr),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_arprot  (arprot),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp),
      .s_axil_rvalid  (rvalid),
      .s_axil_rready  (rready),
      .nbf_opcode_o   (nbf_opcode),
      .nbf_addr_o     (nbf_addr),
      .nbf_data_o     (nbf_data),
      .nbf_v_o        (nbf_v),
      .nbf_ready_i    (nbf_ready),
      .finish_o       (finish)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Command monitor: a transfer happens at the next rising edge
   always begin
      @(negedge clk);
      #1;
      if (rst_n && nbf_v && nbf_ready) cmd_q.push_back({nbf_opcode, nbf_addr, nbf_data});
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [63:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input bit wait_b,
                            input logic [1:0] exp_resp, input string tag);
      bit aw_done;
      bit w_done;
      bit a_hs;
      bit w_hs;
      bit got;
      int c;
      aw_done = 1'b0;
      w_done  = 1'b0;
      c       = 0;
      @(negedge clk);
      awaddr = addr;
      wdata  = data;
      while (!(aw_done && w_done) && c < 60) begin
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         a_hs = awvalid && awready;
         w_hs = wvalid && wready;
         @(negedge clk);
         if (a_hs) aw_done = 1'b1;
         if (w_hs) w_done = 1'b1;
         c++;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (!(aw_done && w_done)) check_val({tag, "_accept"}, {aw_done, w_done}, 2'b11);
      if (wait_b) begin
         got = 1'b0;
         for (int i = 0; i < 30 && !got; i++) begin
            if (bvalid) begin
               got = 1'b1;
               check_val({tag, "_bresp"}, bresp, exp_resp);
            end else begin
               @(negedge clk);
            end
         end
         if (!got) check_val({tag, "_bvalid"}, got, 1'b1);
      end
   endtask

   task automatic send_cmd(input logic [4:0][31:0] w, input string tag);
      for (int i = 0; i < 5; i++)
         axi_write(host_lp, w[i], 0, 0, 1'b1, 2'b00, $sformatf("%s_w%0d", tag, i));
   endtask

   task automatic expect_cmd(input logic [135:0] exp, input string tag);
      int n;
      n = 0;
      while (cmd_q.size() == 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (cmd_q.size() == 0) check_val({tag, "_present"}, cmd_q.size(), 1);
      else check_val(tag, cmd_q.pop_front(), exp);
   endtask

   task automatic axi_read(input logic [31:0] exp, input string tag);
      bit hs;
      bit hs_now;
      int c;
      hs = 1'b0;
      c  = 0;
      @(negedge clk);
      araddr  = 64'h1234;
      arvalid = 1'b1;
      while (!hs && c < 30) begin
         hs_now = arvalid && arready;
         @(negedge clk);
         if (hs_now) hs = 1'b1;
         c++;
      end
      arvalid = 1'b0;
      check_val({tag, "_rvalid"}, rvalid, 1'b1);
      check_val({tag, "_rdata"}, rdata, exp);
      check_val({tag, "_rresp"}, rresp, 2'b00);
   endtask

   // Outputs that must all be zero while reset is held
   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ctl"},
                {nbf_v, finish, bvalid, rvalid, awready, wready, arready, bresp, rresp}, 11'h0);
      check_val({tag, "_rdata"}, rdata, 32'h0);
      check_val({tag, "_cmd"}, {nbf_opcode, nbf_addr, nbf_data}, 136'h0);
   endtask

   initial begin
      logic [4:0][31:0] cmd_a;
      logic [4:0][31:0] cmd_b;
      logic [4:0][31:0] cmd_f;
      logic [135:0] exp_a;
      logic [135:0] exp_b;
      logic [135:0] exp_f;

      cmd_a = {32'hABCD_EF02, 32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
      exp_a = {8'h02, 64'h0000_0044_0000_0033, 64'h0000_0022_0000_0011};
      cmd_b = {32'h0000_0003, 32'h0000_0088, 32'h0000_0077, 32'h0000_0066, 32'h0000_0055};
      exp_b = {8'h03, 64'h0000_0088_0000_0077, 64'h0000_0066_0000_0055};
      cmd_f = {32'h1234_56FF, 32'h0000_00D4, 32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1};
      exp_f = {8'hFF, 64'h0000_00D4_0000_00C3, 64'h0000_00B2_0000_00A1};

      rst_n = 1'b0;  awaddr = 64'h0; awvalid = 1'b0; awprot = 3'h0;
      wdata = 32'h0; wvalid = 1'b0;  wstrb = 4'h0;   bready = 1'b1;
      araddr = 64'h0; arvalid = 1'b0; arprot = 3'h0; rready = 1'b1;
      nbf_ready = 1'b1;

      // Reset state
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("reset_ready_after", {awready, wready, arready}, 3'b111);

      // Happy path
      send_cmd(cmd_a, "happy");
      expect_cmd(exp_a, "happy_cmd");

      // Skewed channels: W leads on word 0, AW leads on word 1
      axi_write(host_lp, cmd_a[0], 3, 0, 1'b1, 2'b00, "skew_w0");
      axi_write(host_lp, cmd_a[1], 0, 2, 1'b1, 2'b00, "skew_w1");
      for (int i = 2; i < 5; i++)
         axi_write(host_lp, cmd_a[i], 0, 0, 1'b1, 2'b00, $sformatf("skew_w%0d", i));
      expect_cmd(exp_a, "skew_cmd");

      // Bad address between word 1 and word 2
      axi_write(host_lp, cmd_b[0], 0, 0, 1'b1, 2'b00, "bad_w0");
      axi_write(host_lp, cmd_b[1], 0, 0, 1'b1, 2'b00, "bad_w1");
      axi_write(bad_lp, 32'hDEAD_BEEF, 0, 0, 1'b1, 2'b10, "bad_slverr");
      for (int i = 2; i < 5; i++)
         axi_write(host_lp, cmd_b[i], 0, 0, 1'b1, 2'b00, $sformatf("bad_w%0d", i));
      expect_cmd(exp_b, "bad_cmd");

      // Backpressure: two commands with the consumer stalled
      @(negedge clk);
      nbf_ready = 1'b0;
      send_cmd(cmd_a, "bp_a");
      for (int i = 0; i < 4; i++)
         axi_write(host_lp, cmd_b[i], 0, 0, 1'b1, 2'b00, $sformatf("bp_b%0d", i));
      axi_write(host_lp, cmd_b[4], 0, 0, 1'b0, 2'b00, "bp_b4");
      repeat (4) @(negedge clk);
      check_val("bp_stalled", {bvalid, awready, wready, nbf_v}, 4'b0001);
      check_val("bp_no_xfer", cmd_q.size(), 0);
      nbf_ready = 1'b1;
      begin
         bit got;
         got = 1'b0;
         for (int i = 0; i < 30 && !got; i++) begin
            if (bvalid) begin
               got = 1'b1;
               check_val("bp_b4_bresp", bresp, 2'b00);
            end else begin
               @(negedge clk);
            end
         end
         if (!got) check_val("bp_b4_bvalid", got, 1'b1);
      end
      expect_cmd(exp_a, "bp_cmd_a");
      expect_cmd(exp_b, "bp_cmd_b");

      // Status before any finish: five transfers, finish clear
      axi_read(32'h0000_000A, "status5");

      // Reset mid-command
      for (int i = 0; i < 3; i++)
         axi_write(host_lp, cmd_a[i], 0, 0, 1'b1, 2'b00, $sformatf("rst_w%0d", i));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("midreset_ready_after", {awready, wready, arready}, 3'b111);
      check_val("finish_clear", finish, 1'b0);

      // Finish command and status
      send_cmd(cmd_f, "fin");
      expect_cmd(exp_f, "fin_cmd");
      repeat (5) @(negedge clk);
      check_val("fin_only_one", cmd_q.size(), 0);
      check_val("fin_flag", finish, 1'b1);
      axi_read(32'h0000_0003, "status_fin");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
